mbx_ombx_reader: RTL and testbench

Outbound-mailbox read engine. It sits directly upstream of the mailbox control FSM: while the FSM reports the Read state, this block fetches the object word by word from the mailbox SRAM window and presents each word to the system interface RDATA register. It advances on each system acknowledge. After the last word is consumed it pulses `sys_read_all_o`, which drives the FSM's `sys_read_all_i`.

---
 rtl/mbx_ombx_reader.sv | 152 +++++++++++++++
 tb/tb_mbx_ombx_reader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbx_ombx_reader.sv
// Outbound mailbox read engine: fetches the object word by word from the SRAM
// window and holds each word in RDATA until the system interface acknowledges it.
module mbx_ombx_reader #(
    parameter int unsigned CfgSramAddrWidth   = 32,
    parameter int unsigned CfgSramDataWidth   = 32,
    parameter int unsigned CfgObjectSizeWidth = 11
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          mbx_read_i,
    input  logic                          mbx_clear_i,
    input  logic [CfgSramAddrWidth-1:0]   sram_base_addr_i,
    input  logic [CfgSramAddrWidth-1:0]   sram_limit_addr_i,
    input  logic [CfgObjectSizeWidth-1:0] object_size_i,
    input  logic                          sysif_read_ack_i,
    output logic [CfgSramDataWidth-1:0]   read_data_o,
    output logic                          read_data_valid_o,
    output logic                          sys_read_all_o,
    output logic                          read_error_o,
    output logic                          sram_req_o,
    output logic [CfgSramAddrWidth-1:0]   sram_addr_o,
    input  logic                          sram_gnt_i,
    input  logic                          sram_rvalid_i,
    input  logic [CfgSramDataWidth-1:0]   sram_rdata_i,
    input  logic                          sram_rerror_i
);
    localparam int unsigned PtrW = CfgSramAddrWidth + 1;
    localparam logic [PtrW-1:0] WordBytes = PtrW'(CfgSramDataWidth / 8);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitResp,
        StHold,
        StDone,
        StFlush,
        StError
    } state_e;

    state_e                        state_q, state_d;
    logic [PtrW-1:0]               ptr_q, ptr_d;
    logic [CfgObjectSizeWidth-1:0] cnt_q, cnt_d;
    logic [CfgSramDataWidth-1:0]   data_q, data_d;
    logic                          all_q, all_d;
    logic                          err_q, err_d;

    logic clr;
    logic overrun;
    logic last_word;
    logic fetch_req;
    logic pending_rsp;

    // Read dropping mid-transfer is handled exactly like an explicit clear.
    assign clr = mbx_clear_i ||
                 (!mbx_read_i && (state_q == StFetch || state_q == StWaitResp ||
                                  state_q == StHold));
    assign overrun   = ptr_q > {1'b0, sram_limit_addr_i};
    assign last_word = cnt_q == CfgObjectSizeWidth'(1);
    assign fetch_req = (state_q == StFetch) && !overrun;
    assign pending_rsp = ((state_q == StWaitResp || state_q == StFlush) && !sram_rvalid_i) ||
                         (fetch_req && sram_gnt_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = pending_rsp ? StFlush : StIdle;
        end else begin
            unique case (state_q)
                StIdle:     if (mbx_read_i) state_d = (object_size_i == '0) ? StDone : StFetch;
                StFetch:    if (overrun) state_d = StError;
                            else if (sram_gnt_i) state_d = StWaitResp;
                StWaitResp: if (sram_rvalid_i) state_d = sram_rerror_i ? StError : StHold;
                StHold:     if (sysif_read_ack_i) state_d = last_word ? StDone : StFetch;
                StDone:     if (!mbx_read_i) state_d = StIdle;
                StFlush:    if (sram_rvalid_i) state_d = StIdle;
                StError:    state_d = StError;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        all_d  = 1'b0;
        err_d  = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            data_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mbx_read_i) begin
                        ptr_d = {1'b0, sram_base_addr_i};
                        cnt_d = object_size_i;
                        all_d = (object_size_i == '0);
                    end
                end
                StFetch: err_d = overrun;
                StWaitResp: begin
                    if (sram_rvalid_i) begin
                        if (sram_rerror_i) err_d = 1'b1;
                        else data_d = sram_rdata_i;
                    end
                end
                StHold: begin
                    if (sysif_read_ack_i) begin
                        cnt_d = cnt_q - CfgObjectSizeWidth'(1);
                        ptr_d = ptr_q + WordBytes;
                        all_d = last_word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            all_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            all_q  <= all_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        sram_req_o        = fetch_req;
        sram_addr_o       = fetch_req ? ptr_q[CfgSramAddrWidth-1:0] : '0;
        read_data_valid_o = (state_q == StHold);
        read_data_o       = data_q;
        sys_read_all_o    = all_q;
        read_error_o      = err_q;
    end

endmodule

// File: tb/tb_mbx_ombx_reader.sv
// Bench for mbx_ombx_reader: a randomized SRAM responder plus a transaction-level
// model of which words, requests and pulses each read session must produce.
`timescale 1ns/1ps
module tb_mbx_ombx_reader;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned OSW = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic           mbx_read_i, mbx_clear_i;
    logic [AW-1:0]  sram_base_addr_i, sram_limit_addr_i;
    logic [OSW-1:0] object_size_i;
    logic           sysif_read_ack_i;
    logic [DW-1:0]  read_data_o;
    logic           read_data_valid_o, sys_read_all_o, read_error_o;
    logic           sram_req_o;
    logic [AW-1:0]  sram_addr_o;
    logic           sram_gnt_i, sram_rvalid_i, sram_rerror_i;
    logic [DW-1:0]  sram_rdata_i;

    always #5 clk = ~clk;

    mbx_ombx_reader #(
        .CfgSramAddrWidth  (AW),
        .CfgSramDataWidth  (DW),
        .CfgObjectSizeWidth(OSW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mbx_read_i       (mbx_read_i),
        .mbx_clear_i      (mbx_clear_i),
        .sram_base_addr_i (sram_base_addr_i),
        .sram_limit_addr_i(sram_limit_addr_i),
        .object_size_i    (object_size_i),
        .sysif_read_ack_i (sysif_read_ack_i),
        .read_data_o      (read_data_o),
        .read_data_valid_o(read_data_valid_o),
        .sys_read_all_o   (sys_read_all_o),
        .read_error_o     (read_error_o),
        .sram_req_o       (sram_req_o),
        .sram_addr_o      (sram_addr_o),
        .sram_gnt_i       (sram_gnt_i),
        .sram_rvalid_i    (sram_rvalid_i),
        .sram_rdata_i     (sram_rdata_i),
        .sram_rerror_i    (sram_rerror_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM responder configuration and contents
    bit          gnt_always = 1'b1;
    int unsigned gnt_pct = 100, lat_min = 0, lat_max = 0;
    bit          ovr_en = 1'b0, err_en = 1'b0;
    logic [31:0] ovr_addr = '0, ovr_data = '0, err_addr = '0;
    logic [31:0] req_log[$];
    int          stab_viol = 0;

    // Session observations
    logic [31:0] got_words[$];
    int          n_all, n_err, all_lag, extra_req, tail_valid;
    bit          timeout;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic int unsigned n_in_range(input logic [31:0] base, input logic [31:0] limit,
                                               input int unsigned size);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < size; i++) begin
            if ({32'h0, base} + 64'(4 * i) <= {32'h0, limit}) n++;
            else break;
        end
        return n;
    endfunction

    initial begin : sram_model
        bit          pend, prev_wait;
        int unsigned dly;
        logic [31:0] paddr, prev_addr;
        pend = 0; prev_wait = 0; dly = 0; paddr = '0; prev_addr = '0;
        sram_gnt_i = 0; sram_rvalid_i = 0; sram_rerror_i = 0; sram_rdata_i = '0;
        forever begin
            @(negedge clk);
            sram_gnt_i = 0; sram_rvalid_i = 0; sram_rerror_i = 0; sram_rdata_i = $urandom();
            if (rst) begin
                pend = 0; prev_wait = 0;
            end else begin
                if (prev_wait && (!sram_req_o || sram_addr_o !== prev_addr)) stab_viol++;
                prev_wait = 0;
                if (pend) begin
                    if (dly == 0) begin
                        sram_rvalid_i = 1;
                        sram_rdata_i  = mem_word(paddr);
                        sram_rerror_i = err_en && (paddr == err_addr);
                        pend = 0;
                    end else dly--;
                end else if (sram_req_o) begin
                    if (gnt_always || $urandom_range(0, 99) < gnt_pct) begin
                        sram_gnt_i = 1; pend = 1; paddr = sram_addr_o;
                        dly = $urandom_range(lat_min, lat_max);
                        req_log.push_back(sram_addr_o);
                    end else begin
                        prev_wait = 1; prev_addr = sram_addr_o;
                    end
                end
            end
        end
    end

    // Runs one Read session, recording consumed words, pulses and requests.
    task automatic run_session(input logic [31:0] base, input logic [31:0] limit,
                               input int unsigned size, input int unsigned ack_pct);
        int unsigned cyc, tail, last_ack;
        bit finished;
        got_words.delete(); req_log.delete();
        n_all = 0; n_err = 0; all_lag = -1; extra_req = 0; tail_valid = 0; timeout = 0;
        cyc = 0; tail = 0; last_ack = 0; finished = 0;
        @(negedge clk);
        sram_base_addr_i = base; sram_limit_addr_i = limit; object_size_i = OSW'(size);
        mbx_read_i = 1; sysif_read_ack_i = 0;
        while (tail < 6) begin
            @(negedge clk);
            cyc++;
            if (cyc > 2000) begin timeout = 1; break; end
            if (sys_read_all_o) begin n_all++; all_lag = int'(cyc - last_ack); end
            if (read_error_o) n_err++;
            if (finished) begin
                tail++;
                if (sram_req_o) extra_req++;
                if (read_data_valid_o) tail_valid++;
            end
            if (sys_read_all_o || read_error_o) finished = 1;
            sysif_read_ack_i = 0;
            if (read_data_valid_o) begin
                if ($urandom_range(0, 99) < ack_pct) begin
                    sysif_read_ack_i = 1; got_words.push_back(read_data_o); last_ack = cyc;
                end
            end else if ($urandom_range(0, 9) == 0) sysif_read_ack_i = 1;
        end
        sysif_read_ack_i = 0; mbx_read_i = 0;
        if (n_err > 0 || timeout) mbx_clear_i = 1;
        @(negedge clk);
        mbx_clear_i = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; mbx_read_i = 0; mbx_clear_i = 0; sysif_read_ack_i = 0;
        sram_base_addr_i = '0; sram_limit_addr_i = '0; object_size_i = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({read_data_o, read_data_valid_o, sys_read_all_o, read_error_o, sram_req_o, sram_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%0b valid=%0b data=%0h addr=%0h, expected all 0",
                     sram_req_o, read_data_valid_o, read_data_o, sram_addr_o);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        gnt_always = 1; lat_min = 0; lat_max = 0;
        run_session(32'h1000, 32'h100C, 3, 100);
        n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL basic_timeout: got 1 expected 0"); end
        n_checks++; if (got_words.size() != 3) begin n_fail++; $display("FAIL basic_nwords: got %0d expected 3", got_words.size()); end
        for (int i = 0; i < 3 && i < got_words.size(); i++) begin
            n_checks++;
            if (got_words[i] !== mem_word(32'h1000 + 32'(4 * i))) begin
                n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_words[i], mem_word(32'h1000 + 32'(4 * i)));
            end
        end
        n_checks++; if (req_log.size() != 3) begin n_fail++; $display("FAIL basic_nreq: got %0d expected 3", req_log.size()); end
        for (int i = 0; i < 3 && i < req_log.size(); i++) begin
            n_checks++;
            if (req_log[i] !== 32'h1000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, req_log[i], 32'h1000 + 32'(4 * i));
            end
        end
        n_checks++; if (n_all != 1 || all_lag != 1) begin n_fail++; $display("FAIL basic_read_all: got count=%0d lag=%0d expected 1/1", n_all, all_lag); end
        n_checks++; if (n_err != 0 || extra_req != 0) begin n_fail++; $display("FAIL basic_extra: got err=%0d extra_req=%0d expected 0/0", n_err, extra_req); end
    endtask

    task automatic test_size_zero();
        int bad;
        req_log.delete();
        @(negedge clk);
        sram_base_addr_i = 32'h5000; sram_limit_addr_i = 32'h5FFF; object_size_i = '0; mbx_read_i = 1;
        @(negedge clk);
        n_checks++; if (sys_read_all_o !== 1 || sram_req_o !== 0) begin n_fail++; $display("FAIL zero_pulse: got all=%0b req=%0b expected 1/0", sys_read_all_o, sram_req_o); end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (sys_read_all_o || sram_req_o || read_data_valid_o) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL zero_quiet: got %0d active cycles expected 0", bad); end
        mbx_read_i = 0;
        repeat (2) @(negedge clk);
        mbx_read_i = 1;
        @(negedge clk);
        n_checks++; if (sys_read_all_o !== 1) begin n_fail++; $display("FAIL zero_rearm: got all=%0b expected 1", sys_read_all_o); end
        mbx_read_i = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_log.size() != 0) begin n_fail++; $display("FAIL zero_noreq: got %0d requests expected 0", req_log.size()); end
    endtask

    task automatic test_overrun();
        gnt_always = 0; gnt_pct = 60; lat_min = 0; lat_max = 2;
        run_session(32'h1000, 32'h1004, 3, 80);
        n_checks++; if (got_words.size() != 2) begin n_fail++; $display("FAIL ovr_nwords: got %0d expected 2", got_words.size()); end
        n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL ovr_nreq: got %0d expected 2", req_log.size()); end
        n_checks++; if (n_err != 1 || n_all != 0) begin n_fail++; $display("FAIL ovr_pulses: got err=%0d all=%0d expected 1/0", n_err, n_all); end
        n_checks++; if (extra_req != 0 || tail_valid != 0) begin n_fail++; $display("FAIL ovr_stuck: got req=%0d valid=%0d in Error expected 0/0", extra_req, tail_valid); end
    endtask

    task automatic test_rerror();
        gnt_always = 1; lat_min = 1; lat_max = 1;
        err_en = 1; err_addr = 32'h3004;
        run_session(32'h3000, 32'h3FFF, 4, 100);
        err_en = 0;
        n_checks++; if (got_words.size() != 1) begin n_fail++; $display("FAIL rerr_nwords: got %0d expected 1", got_words.size()); end
        n_checks++; if (n_err != 1 || n_all != 0) begin n_fail++; $display("FAIL rerr_pulses: got err=%0d all=%0d expected 1/0", n_err, n_all); end
        n_checks++; if (tail_valid != 0 || req_log.size() != 2) begin n_fail++; $display("FAIL rerr_after: got valid=%0d nreq=%0d expected 0/2", tail_valid, req_log.size()); end
    endtask

    task automatic test_clear_in_grant();
        bit seen;
        int bad;
        gnt_always = 1; lat_min = 2; lat_max = 2;
        ovr_en = 1; ovr_addr = 32'h2000; ovr_data = 32'hDEADBEEF;
        @(negedge clk);
        sram_base_addr_i = 32'h2000; sram_limit_addr_i = 32'h2FFF; object_size_i = OSW'(2); mbx_read_i = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_req_o) begin seen = 1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL clr_req_timeout: got no request expected one"); end
        mbx_clear_i = 1; mbx_read_i = 0;
        @(negedge clk);
        mbx_clear_i = 0;
        n_checks++;
        if ({read_data_o, read_data_valid_o, sys_read_all_o, read_error_o, sram_req_o} !== '0) begin
            n_fail++; $display("FAIL clr_outputs: got data=%h valid=%0b req=%0b expected 0", read_data_o, read_data_valid_o, sram_req_o);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (read_data_valid_o || read_data_o !== '0 || read_error_o) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clr_flush: got %0d bad cycles expected 0", bad); end
        lat_min = 0; lat_max = 1;
        run_session(32'h2000, 32'h2FFF, 2, 100);
        n_checks++;
        if (got_words.size() != 2 || req_log.size() == 0 || req_log[0] !== 32'h2000 || got_words[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL clr_restart: got nwords=%0d first=%h expected 2 words from base", got_words.size(),
                               got_words.size() > 0 ? got_words[0] : 32'h0);
        end
        n_checks++; if (n_all != 1) begin n_fail++; $display("FAIL clr_restart_all: got %0d expected 1", n_all); end
        ovr_en = 0;
    endtask

    task automatic test_early_ack_reset();
        bit seen;
        int bad;
        gnt_always = 1; lat_min = 3; lat_max = 3;
        req_log.delete();
        @(negedge clk);
        sram_base_addr_i = 32'h4000; sram_limit_addr_i = 32'h4FFF; object_size_i = OSW'(3); mbx_read_i = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_req_o) begin seen = 1; break; end
        end
        // ack held for two cycles while the first response is still in flight
        sysif_read_ack_i = 1;
        repeat (2) @(negedge clk);
        sysif_read_ack_i = 0;
        for (int i = 0; i < 20 && !read_data_valid_o; i++) @(negedge clk);
        n_checks++;
        if (!seen || read_data_valid_o !== 1 || read_data_o !== mem_word(32'h4000)) begin
            n_fail++; $display("FAIL early_first: got valid=%0b data=%h expected 1/%h", read_data_valid_o, read_data_o, mem_word(32'h4000));
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (!read_data_valid_o) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL early_ignored: got %0d cycles without valid expected 0", bad); end
        sysif_read_ack_i = 1;
        @(negedge clk);
        sysif_read_ack_i = 0;
        n_checks++;
        if (read_data_valid_o !== 0 || sram_req_o !== 1 || sram_addr_o !== 32'h4004) begin
            n_fail++; $display("FAIL early_next: got valid=%0b req=%0b addr=%h expected 0/1/4004", read_data_valid_o, sram_req_o, sram_addr_o);
        end
        for (int i = 0; i < 20 && !read_data_valid_o; i++) @(negedge clk);
        #2 rst = 1;
        #1;
        n_checks++;
        if ({read_data_o, read_data_valid_o, sys_read_all_o, read_error_o, sram_req_o, sram_addr_o} !== '0) begin
            n_fail++; $display("FAIL async_reset: got valid=%0b data=%h req=%0b expected all 0", read_data_valid_o, read_data_o, sram_req_o);
        end
        n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL early_nreq: got %0d expected 2", req_log.size()); end
        @(negedge clk);
        mbx_read_i = 0;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] base, limit;
        int unsigned size, n_ok, e_idx, exp_words, exp_reqs, exp_err, exp_all;
        for (int it = 0; it < 25; it++) begin
            if (it == 0) begin
                base = 32'hFFFF_FFF8; limit = 32'hFFFF_FFFC; size = 4;
            end else begin
                base  = 32'h1000 + ($urandom_range(0, 255) << 2);
                limit = base - 32'd4 + ($urandom_range(0, 8) << 2);
                size  = $urandom_range(0, 6);
            end
            gnt_always = 0; gnt_pct = $urandom_range(30, 100);
            lat_min = 0; lat_max = $urandom_range(0, 3);
            err_en = (size > 0) && ($urandom_range(0, 3) == 0);
            e_idx = err_en ? $urandom_range(0, size - 1) : size;
            err_addr = base + 32'(4 * e_idx);
            n_ok = n_in_range(base, limit, size);
            if (e_idx < n_ok) begin
                exp_words = e_idx; exp_reqs = e_idx + 1; exp_err = 1; exp_all = 0;
            end else if (n_ok < size) begin
                exp_words = n_ok; exp_reqs = n_ok; exp_err = 1; exp_all = 0;
            end else begin
                exp_words = size; exp_reqs = size; exp_err = 0; exp_all = 1;
            end
            run_session(base, limit, size, $urandom_range(30, 100));
            err_en = 0;
            n_checks++;
            if (timeout || got_words.size() != exp_words) begin
                n_fail++; $display("FAIL rnd%0d_nwords: got %0d (timeout=%0b) expected %0d", it, got_words.size(), timeout, exp_words);
            end
            for (int i = 0; i < int'(exp_words) && i < got_words.size(); i++) begin
                n_checks++;
                if (got_words[i] !== mem_word(base + 32'(4 * i))) begin
                    n_fail++; $display("FAIL rnd%0d_data[%0d]: got %h expected %h", it, i, got_words[i], mem_word(base + 32'(4 * i)));
                end
            end
            n_checks++;
            if (req_log.size() != exp_reqs) begin
                n_fail++; $display("FAIL rnd%0d_nreq: got %0d expected %0d", it, req_log.size(), exp_reqs);
            end
            for (int i = 0; i < int'(exp_reqs) && i < req_log.size(); i++) begin
                n_checks++;
                if (req_log[i] !== base + 32'(4 * i)) begin
                    n_fail++; $display("FAIL rnd%0d_addr[%0d]: got %h expected %h", it, i, req_log[i], base + 32'(4 * i));
                end
            end
            n_checks++;
            if (n_err != int'(exp_err) || n_all != int'(exp_all) || (exp_all == 1 && all_lag != 1)) begin
                n_fail++; $display("FAIL rnd%0d_pulses: got err=%0d all=%0d lag=%0d expected %0d/%0d/1", it, n_err, n_all, all_lag, exp_err, exp_all);
            end
            n_checks++;
            if (extra_req != 0 || tail_valid != 0) begin
                n_fail++; $display("FAIL rnd%0d_tail: got req=%0d valid=%0d expected 0/0", it, extra_req, tail_valid);
            end
        end
        n_checks++;
        if (stab_viol != 0) begin n_fail++; $display("FAIL req_stable: got %0d violations expected 0", stab_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size_zero();
        test_overrun();
        test_rerror();
        test_clear_in_grant();
        test_early_ack_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
